// File: rtl/fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_if
// Handshake bundle between the FIFO pointer/flag controller and its users.
//   master : producer/consumer side. Drives wr/rd and observes everything else.
//   slave  : controller side. Receives wr/rd and drives the RAM controls
//            (we, w_addr, r_addr) and the status flags.
// Signals:
//   wr, rd              push / pop requests
//   we, w_addr, r_addr  RAM write enable, write address, read address
//   full, empty         occupancy flags
//   ovf, udf            rejected push / rejected pop pulses
//   level               stored word count (0 .. 2**ADDR_WIDTH)
//   almost_full/empty   threshold flags
// -----------------------------------------------------------------------------
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  wr;
    logic                  rd;
    logic                  we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic                  ovf;
    logic                  udf;
    logic [ADDR_WIDTH:0]   level;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output wr, rd,
        input  we, w_addr, r_addr, full, empty, ovf, udf,
               level, almost_full, almost_empty
    );

    modport slave (
        input  wr, rd,
        output we, w_addr, r_addr, full, empty, ovf, udf,
               level, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer/flag controller for a first-word-fall-through FIFO built around a
// distributed dual-port RAM with combinational read. The head word is on the
// RAM r_data whenever empty is low, so a pop consumes it in the same cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_ctrl_if.slave: wr/rd in; we (combinational), w_addr, r_addr,
//          full, empty, ovf, udf, level, almost_full, almost_empty out
//
// Build option:
//   FIFO_CTRL_LEVEL_EN  when defined, a registered occupancy counter drives
//                       level/almost_full/almost_empty; otherwise those
//                       outputs are tied to 0.
// -----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    fifo_ctrl_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0] AE_THRESH = (ADDR_WIDTH+1)'(AE_MARGIN);

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, w_ptr_inc;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d, r_ptr_inc;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push_ok, pop_ok;

    // A push into a full FIFO is allowed when a pop frees the head slot at the
    // same edge; a pop from an empty FIFO is never allowed, even with a push.
    always_comb begin
        push_ok   = bus.wr & (~full_q | bus.rd);
        pop_ok    = bus.rd & ~empty_q;
        w_ptr_inc = w_ptr_q + ADDR_WIDTH'(1);
        r_ptr_inc = r_ptr_q + ADDR_WIDTH'(1);

        w_ptr_d = push_ok ? w_ptr_inc : w_ptr_q;
        r_ptr_d = pop_ok  ? r_ptr_inc : r_ptr_q;
        full_d  = full_q;
        empty_d = empty_q;

        // Pointer equality alone is ambiguous (full vs empty), so the flags
        // are resolved from the direction of the last single-sided move.
        if (push_ok && !pop_ok) begin
            empty_d = 1'b0;
            full_d  = (w_ptr_inc == r_ptr_q);
        end else if (pop_ok && !push_ok) begin
            full_d  = 1'b0;
            empty_d = (r_ptr_inc == w_ptr_q);
        end

        ovf_d = bus.wr & ~push_ok;
        udf_d = bus.rd & ~pop_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.we     = push_ok;
    assign bus.w_addr = w_ptr_q;
    assign bus.r_addr = r_ptr_q;
    assign bus.full   = full_q;
    assign bus.empty  = empty_q;
    assign bus.ovf    = ovf_q;
    assign bus.udf    = udf_q;

`ifdef FIFO_CTRL_LEVEL_EN
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic                almost_full_q, almost_full_d;
    logic                almost_empty_q, almost_empty_d;

    // Thresholds are evaluated on the next count so the flags are registered
    // in step with level rather than lagging it by a cycle.
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + (ADDR_WIDTH+1)'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - (ADDR_WIDTH+1)'(1);
        end
        almost_full_d  = (level_d >= AF_THRESH);
        almost_empty_d = (level_d <= AE_THRESH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q        <= '0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            level_q        <= level_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign bus.level        = level_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
`else
    // Thresholds have no consumer in this build.
    logic unused_thresh;
    assign unused_thresh = ^{AF_THRESH, AE_THRESH};

    assign bus.level        = '0;
    assign bus.almost_full  = 1'b0;
    assign bus.almost_empty = 1'b0;
`endif

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO pointer/flag controller that sits directly upstream of the distributed dual-port RAM and drives its `we`, `w_addr` and `r_addr` inputs. It converts producer push and consumer pop requests into RAM write-enables and addresses, and tracks full and empty. Together with the RAM it forms a first-word-fall-through FIFO: the RAM's combinational `r_data` is the head word whenever `empty` is low.

## Interface
- `ADDR_WIDTH`, 3, RAM address width; FIFO depth is 2**ADDR_WIDTH words.
- `AF_MARGIN`, 1, `almost_full` asserts when free slots are at or below this value (LEVEL build only).
- `AE_MARGIN`, 1, `almost_empty` asserts when stored words are at or below this value (LEVEL build only).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr`  in  1  push request from the producer.
- `rd`  in  1  pop request from the consumer; the head word is taken in the same cycle from RAM `r_data`.
- `we`  out  1  RAM write enable (combinational).
- `w_addr`  out  ADDR_WIDTH  RAM write address (write pointer, registered).
- `r_addr`  out  ADDR_WIDTH  RAM read address (read pointer, registered).
- `full`  out  1  FIFO holds 2**ADDR_WIDTH words (registered).
- `empty`  out  1  FIFO holds 0 words (registered).
- `ovf`  out  1  one-cycle pulse: a push was rejected in the previous cycle (registered).
- `udf`  out  1  one-cycle pulse: a pop was rejected in the previous cycle (registered).
- `level`  out  ADDR_WIDTH+1  stored word count, 0 to 2**ADDR_WIDTH.
- `almost_full`, `almost_empty`  out  1  threshold flags.

## Operation
- Accept rules, evaluated combinationally in the current cycle:
  - push_ok = `wr & (~full | rd)`
  - pop_ok = `rd & ~empty`
  - `we` = push_ok.
- On a rising edge:
  - push_ok advances `w_addr` by 1, modulo 2**ADDR_WIDTH. Wrap-around from 2**ADDR_WIDTH-1 to 0 is natural.
  - pop_ok advances `r_addr` by 1, with the same modulo wrap.
- Flag update:
  - push only: `empty` <- 0; `full` <- 1 if the next `w_addr` equals `r_addr`.
  - pop only: `full` <- 0; `empty` <- 1 if the next `r_addr` equals `w_addr`.
  - push and pop together: both pointers advance and the flags are unchanged. This applies when the FIFO is full: the head word is consumed and the freed slot is written in the same edge.
  - Neither: hold.
- Empty with `wr` and `rd` both high: the pop is rejected (`udf` pulses), the push is accepted, and `empty` goes to 0.
- `ovf` <- `wr & ~push_ok`. `udf` <- `rd & ~pop_ok`. Both are cleared on the following edge unless the condition repeats.
- Control state is only {w_ptr, r_ptr, full, empty, ovf, udf}. No other FSM exists.
- Reset, asynchronous, effective immediately:
  - `w_addr` = `r_addr` = 0, `empty` = 1, `full` = 0, `ovf` = `udf` = 0.
  - `level` = 0, `almost_empty` = 1, `almost_full` = 0.
  - Reset in mid-operation discards all contents. RAM contents are not cleared and are don't-care.

## Timing
- Push latency: a word accepted at edge N is visible on `r_data` (if it is the head) and `empty` falls after edge N.
- Pop: the data is sampled by the consumer in the same cycle as `rd`; the pointer moves at that edge.
- `we` is the only combinational output. It depends on `wr`, `rd`, `full`.
- All other outputs are registered or derived from registers only; there is no input-to-output path.
- Throughput is one push and one pop per cycle, sustained, including at full.

## Configuration
- Macro: `FIFO_CTRL_LEVEL_EN`.
- Defined:
  - A registered `level` counter: +1 on push-only, -1 on pop-only, hold otherwise.
  - `almost_full` = (`level` >= 2**ADDR_WIDTH - AF_MARGIN), registered alongside `level`.
  - `almost_empty` = (`level` <= AE_MARGIN), registered alongside `level`.
- Not defined: the counter is not built; `level`, `almost_full` and `almost_empty` are tied to 0. Ports are always present.

## Test plan
(ADDR_WIDTH=3, depth 8, LEVEL build unless noted)
- Reset → `w_addr`=0, `r_addr`=0, `empty`=1, `full`=0, `level`=0, `almost_empty`=1. Assert `rst_n` mid-burst → same values immediately, without waiting for a clock edge.
- 8 consecutive pushes of 0x10..0x17 → `full`=1 after the 8th edge, `w_addr`=0 (wrapped), `level`=8, `almost_full` set after the 7th. A 9th push → `we`=0, `ovf` pulses for one cycle, contents unchanged.
- From full, 8 pops → `r_data` reads 0x10..0x17 in order, `empty`=1 after the 8th. A 9th pop → `udf` pulses, `r_addr` stays 0.
- Full with `wr`=`rd`=1 writing 0x20 → `we`=1, `full` stays 1, `r_addr`=1, `w_addr`=1. After draining, 0x20 is the last word read.
- Empty with `wr`=`rd`=1 writing 0x33 → `udf` pulses, `empty`=0, `level`=1, `r_data`=0x33 the next cycle.
- Without `FIFO_CTRL_LEVEL_EN`: repeat the fill test → `full`/`empty`/`ovf` identical; `level`, `almost_full`, `almost_empty` stay 0.
